dmem_responder: RTL

//  Responder end of the core's external data-memory interface: receives we/addr/wdata/storetype

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_lane_align.sv | 37 +++
 rtl/dmem_responder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [2:0] {
        ST_BYTE = 3'b000,
        ST_HALF = 3'b001,
        ST_WORD = 3'b010
    } storetype_e;

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_e;

    localparam int unsigned DMEM_AW_DEFAULT = 11;

    function automatic int unsigned dmem_depth(input int unsigned aw);
        return 32'd1 << (aw - 2);
    endfunction

    function automatic int unsigned dmem_idx_width(input int unsigned aw);
        return aw - 2;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Maps a right-aligned store onto little-endian byte lanes and classifies it.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_storetype,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    output logic        o_illegal
);

    always_comb begin
        o_be         = '0;
        o_wdata      = i_wdata;
        o_misaligned = 1'b0;
        o_illegal    = 1'b0;
        case (i_storetype)
            ST_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            ST_HALF: begin
                o_misaligned = i_addr_lo[0];
                o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_wdata[15:0]}};
            end
            ST_WORD: begin
                o_misaligned = (i_addr_lo != 2'b00);
                o_be         = '1;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with byte-lane stores, post-reset clear
// sweep, sticky store-fault flags and a saturating committed-store counter.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH      = 32,
    parameter int unsigned P_DMEM_ADDR_WIDTH = DMEM_AW_DEFAULT,
    parameter int unsigned P_CNT_WIDTH       = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_dmem_we,
    input  logic [P_DMEM_ADDR_WIDTH-1:0] i_dmem_addr,
    input  logic [P_DATA_WIDTH-1:0]      i_dmem_wdata,
    input  logic [2:0]                   i_dmem_storetype,
    output logic [P_DATA_WIDTH-1:0]      o_dmem_rdata,
    output logic                         o_init_done,
    output logic                         o_misaligned,
    output logic                         o_illegal_st,
    output logic [P_CNT_WIDTH-1:0]       o_store_count
);

    localparam int unsigned DEPTH = dmem_depth(P_DMEM_ADDR_WIDTH);
    localparam int unsigned IDX_W = dmem_idx_width(P_DMEM_ADDR_WIDTH);

    logic [P_DATA_WIDTH-1:0] mem [DEPTH];

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       clr_idx_q, clr_idx_d;
    logic                   misaligned_q, misaligned_d;
    logic                   illegal_q, illegal_d;
    logic [P_CNT_WIDTH-1:0] count_q, count_d;

    logic [IDX_W-1:0]        word_idx;
    logic [3:0]              st_be;
    logic [31:0]             st_wdata;
    logic                    st_mis, st_ill;
    logic                    ready, store_ok;
    logic                    mem_we;
    logic [IDX_W-1:0]        mem_idx;
    logic [3:0]              mem_be;
    logic [P_DATA_WIDTH-1:0] mem_wdata;

    assign word_idx = i_dmem_addr[P_DMEM_ADDR_WIDTH-1:2];

    dmem_lane_align u_lane_align (
        .i_storetype  (i_dmem_storetype),
        .i_addr_lo    (i_dmem_addr[1:0]),
        .i_wdata      (i_dmem_wdata),
        .o_be         (st_be),
        .o_wdata      (st_wdata),
        .o_misaligned (st_mis),
        .o_illegal    (st_ill)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_CLEAR;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == S_CLEAR && clr_idx_q == IDX_W'(DEPTH - 1))
            state_d = S_READY;
    end

    // The single RAM write port is shared: the sweep owns it in CLEAR, stores in READY.
    always_comb begin
        ready     = (state_q == S_READY);
        store_ok  = ready && i_dmem_we && !st_mis && !st_ill;
        mem_we    = 1'b0;
        mem_idx   = word_idx;
        mem_be    = st_be;
        mem_wdata = st_wdata;
        if (!ready) begin
            mem_we    = 1'b1;
            mem_idx   = clr_idx_q;
            mem_be    = '1;
            mem_wdata = '0;
        end else if (store_ok) begin
            mem_we = 1'b1;
        end
    end

    always_comb begin
        clr_idx_d    = ready ? clr_idx_q : clr_idx_q + 1'b1;
        misaligned_d = misaligned_q | (ready && i_dmem_we && st_mis);
        illegal_d    = illegal_q | (ready && i_dmem_we && st_ill);
        count_d      = (store_ok && count_q != '1) ? count_q + 1'b1 : count_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clr_idx_q    <= '0;
            misaligned_q <= 1'b0;
            illegal_q    <= 1'b0;
            count_q      <= '0;
        end else begin
            clr_idx_q    <= clr_idx_d;
            misaligned_q <= misaligned_d;
            illegal_q    <= illegal_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        o_dmem_rdata  = ready ? mem[word_idx] : '0;
        o_init_done   = ready;
        o_misaligned  = misaligned_q;
        o_illegal_st  = illegal_q;
        o_store_count = count_q;
    end

endmodule
